// File: rtl/pmu_pkg.sv
// Shared types and defaults for the PMU bitstream load sequencer.
package pmu_pkg;

  localparam int unsigned LEN_W_DEF    = 16;
  localparam int unsigned CHK_BITS_DEF = 32;

  typedef enum logic [2:0] {
    PMU_IDLE = 3'd0,
    PMU_HDR  = 3'd1,
    PMU_PAY  = 3'd2,
    PMU_CHK  = 3'd3,
    PMU_EVAL = 3'd4,
    PMU_DONE = 3'd5,
    PMU_LOCK = 3'd6
  } pmu_ld_state_t;

endpackage

// File: rtl/pmu_load_ctrl.sv
// Secured bitstream load sequencer: frames header/payload/checksum bits from the
// serial stream, gates the config chain and checksum unit, and flags done or lock.
module pmu_load_ctrl
  import pmu_pkg::*;
#(
  parameter int unsigned LEN_W    = LEN_W_DEF,
  parameter int unsigned CHK_BITS = CHK_BITS_DEF
) (
  input  logic             tck_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             en_i,
  input  logic             data_i,
  input  logic             chk_flag_i,
  output logic             chk_en_o,
  output logic             chk_clr_o,
  output logic             ccff_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             lock_o,
  output logic [LEN_W-1:0] bit_cnt_o
);

  localparam int unsigned HDR_CW = $clog2(LEN_W + 1);
  localparam int unsigned CHK_CW = $clog2(CHK_BITS + 1);

  pmu_ld_state_t     state;
  logic [LEN_W-1:0]  len;
  logic [HDR_CW-1:0] hdr_cnt;
  logic [CHK_CW-1:0] chk_cnt;
  logic [LEN_W-1:0]  len_shift;

  assign len_shift = {len[LEN_W-2:0], data_i};

  // Payload and checksum beats are forwarded straight from the bit strobe.
  assign chk_en_o  = en_i & ((state == PMU_PAY) | (state == PMU_CHK));
  assign ccff_en_o = en_i & (state == PMU_PAY);

  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      state     <= PMU_IDLE;
      chk_clr_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      lock_o    <= 1'b0;
      bit_cnt_o <= '0;
      len       <= '0;
      hdr_cnt   <= '0;
      chk_cnt   <= '0;
    end else begin
      chk_clr_o <= 1'b0;
      unique case (state)
        PMU_IDLE, PMU_DONE, PMU_LOCK: begin
          if (start_i) begin
            state     <= PMU_HDR;
            chk_clr_o <= 1'b1;
            busy_o    <= 1'b1;
            done_o    <= 1'b0;
            lock_o    <= 1'b0;
            bit_cnt_o <= '0;
            len       <= '0;
            hdr_cnt   <= '0;
            chk_cnt   <= '0;
          end
        end

        PMU_HDR: begin
          if (abort_i) begin
            state  <= PMU_LOCK;
            busy_o <= 1'b0;
            lock_o <= 1'b1;
          end else if (en_i) begin
            len     <= len_shift;
            hdr_cnt <= hdr_cnt + HDR_CW'(1);
            if (hdr_cnt == HDR_CW'(LEN_W - 1)) begin
              // An empty payload cannot be authenticated, so it locks immediately.
              if (len_shift == '0) begin
                state  <= PMU_LOCK;
                busy_o <= 1'b0;
                lock_o <= 1'b1;
              end else begin
                state <= PMU_PAY;
              end
            end
          end
        end

        PMU_PAY: begin
          if (abort_i) begin
            state  <= PMU_LOCK;
            busy_o <= 1'b0;
            lock_o <= 1'b1;
          end else if (en_i) begin
            bit_cnt_o <= bit_cnt_o + LEN_W'(1);
            if (bit_cnt_o == len - LEN_W'(1)) begin
              state <= PMU_CHK;
            end
          end
        end

        PMU_CHK: begin
          if (abort_i) begin
            state  <= PMU_LOCK;
            busy_o <= 1'b0;
            lock_o <= 1'b1;
          end else if (en_i) begin
            chk_cnt <= chk_cnt + CHK_CW'(1);
            if (chk_cnt == CHK_CW'(CHK_BITS - 1)) begin
              state <= PMU_EVAL;
            end
          end
        end

        // One settle cycle for the checksum flag, then judge.
        PMU_EVAL: begin
          busy_o <= 1'b0;
          if (abort_i || chk_flag_i) begin
            state  <= PMU_LOCK;
            lock_o <= 1'b1;
          end else begin
            state  <= PMU_DONE;
            done_o <= 1'b1;
          end
        end

        default: begin
          state  <= PMU_LOCK;
          busy_o <= 1'b0;
          lock_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmu_load_ctrl.sv
// Self-checking bench for pmu_load_ctrl: scoreboarded load runs plus reset/abort corners.
module tb_pmu_load_ctrl;

  localparam int unsigned LEN_W    = 16;
  localparam int unsigned CHK_BITS = 32;

  logic             tck_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic             en_i = 1'b0;
  logic             data_i = 1'b0;
  logic             chk_flag_i = 1'b0;
  logic             chk_en_o;
  logic             chk_clr_o;
  logic             ccff_en_o;
  logic             busy_o;
  logic             done_o;
  logic             lock_o;
  logic [LEN_W-1:0] bit_cnt_o;

  pmu_load_ctrl #(.LEN_W(LEN_W), .CHK_BITS(CHK_BITS)) dut (
    .tck_i      (tck_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .en_i       (en_i),
    .data_i     (data_i),
    .chk_flag_i (chk_flag_i),
    .chk_en_o   (chk_en_o),
    .chk_clr_o  (chk_clr_o),
    .ccff_en_o  (ccff_en_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .lock_o     (lock_o),
    .bit_cnt_o  (bit_cnt_o)
  );

  always #5 tck_i = ~tck_i;

  typedef struct {
    logic        done;
    logic        lock;
    int unsigned bit_cnt;
    int unsigned ccff_beats;
    int unsigned chk_beats;
    int unsigned latency;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  // Beat counters sampled mid-cycle, when the combinational enables are settled.
  int unsigned ccff_seen = 0;
  int unsigned chken_seen = 0;
  int unsigned clr_seen = 0;

  always @(negedge tck_i) begin
    if (ccff_en_o) ccff_seen++;
    if (chk_en_o)  chken_seen++;
    if (chk_clr_o) clr_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck_i);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit gaps);
    if (gaps) begin
      for (int g = 0; g < 4; g++) begin
        if ($urandom_range(0, 1) == 0) break;
        tick();
      end
    end
    en_i   = 1'b1;
    data_i = b;
    tick();
    en_i   = 1'b0;
    data_i = 1'b0;
  endtask

  task automatic send_header(input logic [LEN_W-1:0] l, input bit gaps);
    for (int i = LEN_W - 1; i >= 0; i--) send_bit(l[i], gaps);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  int unsigned base_ccff, base_chken, base_clr;

  // Drive one full load and push the result the model expects.
  task automatic run_load(input logic [LEN_W-1:0] l, input logic flag, input bit gaps);
    exp_t e;
    base_ccff  = ccff_seen;
    base_chken = chken_seen;
    base_clr   = clr_seen;
    chk_flag_i = flag;
    pulse_start();
    send_header(l, gaps);
    if (l != 0) begin
      for (int i = 0; i < int'(l); i++) send_bit(1'($urandom_range(0, 1)), gaps);
      for (int i = 0; i < int'(CHK_BITS); i++) send_bit(1'($urandom_range(0, 1)), gaps);
    end
    e.done       = (l != 0) && !flag;
    e.lock       = (l == 0) || flag;
    e.bit_cnt    = l;
    e.ccff_beats = l;
    e.chk_beats  = (l == 0) ? 0 : int'(l) + CHK_BITS;
    e.latency    = (l == 0) ? 0 : 1;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for the sticky result, then compare against the scoreboard.
  task automatic collect(input string tag);
    exp_t        e;
    int unsigned lat = 0;
    while (!(done_o || lock_o) && lat < 10) begin
      tick();
      lat++;
    end
    e = exp_q.pop_front();
    check({tag, "_result_seen"}, 32'(done_o | lock_o), 32'd1);
    check({tag, "_latency"}, lat, e.latency);
    check({tag, "_done"}, 32'(done_o), 32'(e.done));
    check({tag, "_lock"}, 32'(lock_o), 32'(e.lock));
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_bit_cnt"}, 32'(bit_cnt_o), e.bit_cnt);
    check({tag, "_ccff_beats"}, ccff_seen - base_ccff, e.ccff_beats);
    check({tag, "_chk_beats"}, chken_seen - base_chken, e.chk_beats);
    check({tag, "_clr_pulses"}, clr_seen - base_clr, 32'd1);
  endtask

  initial begin
    // Power-on reset.
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_lock", 32'(lock_o), 32'd0);
    check("rst_bit_cnt", 32'(bit_cnt_o), 32'd0);
    check("rst_clr", 32'(chk_clr_o), 32'd0);

    // Reset in the middle of the payload.
    pulse_start();
    send_header(16'h0005, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("midpay_bit_cnt", 32'(bit_cnt_o), 32'd2);
    base_clr = clr_seen;
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_done", 32'(done_o), 32'd0);
    check("midrst_lock", 32'(lock_o), 32'd0);
    check("midrst_bit_cnt", 32'(bit_cnt_o), 32'd0);
    en_i = 1'b1;
    #2;
    check("midrst_ccff_idle", 32'(ccff_en_o), 32'd0);
    en_i = 1'b0;
    tick();
    check("midrst_no_clr", clr_seen - base_clr, 32'd0);

    // Gapless good load, then a failing one.
    run_load(16'h0005, 1'b0, 1'b0);
    collect("good5");

    // start together with abort in DONE: start wins.
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    check("start_abort_busy", 32'(busy_o), 32'd1);
    check("start_abort_done", 32'(done_o), 32'd0);
    check("start_abort_lock", 32'(lock_o), 32'd0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("hdr_abort_lock", 32'(lock_o), 32'd1);

    run_load(16'h0005, 1'b1, 1'b0);
    collect("bad5");

    // Restart from LOCK clears the flag and pulses clear for one cycle.
    base_clr = clr_seen;
    pulse_start();
    check("relock_lock_clr", 32'(lock_o), 32'd0);
    check("relock_clr_pulse", 32'(chk_clr_o), 32'd1);
    check("relock_bit_cnt", 32'(bit_cnt_o), 32'd0);
    tick();
    check("relock_clr_drop", 32'(chk_clr_o), 32'd0);
    check("relock_clr_count", clr_seen - base_clr, 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;

    // Zero-length header locks right after the last header bit.
    run_load(16'h0000, 1'b0, 1'b0);
    collect("zero_len");

    // Random en_i gaps in every phase.
    run_load(16'h0003, 1'b0, 1'b1);
    collect("gappy3");
    run_load(16'h0003, 1'b0, 1'b0);
    collect("gapless3");

    // Abort on the second payload beat; start during PAY is ignored.
    pulse_start();
    send_header(16'h0005, 1'b0);
    base_clr = clr_seen;
    start_i = 1'b1;
    en_i    = 1'b1;
    tick();
    start_i = 1'b0;
    en_i    = 1'b0;
    check("pay_start_busy", 32'(busy_o), 32'd1);
    check("pay_start_bit_cnt", 32'(bit_cnt_o), 32'd1);
    check("pay_start_no_clr", 32'(chk_clr_o), 32'd0);
    abort_i = 1'b1;
    en_i    = 1'b1;
    tick();
    abort_i = 1'b0;
    en_i    = 1'b0;
    check("abort_lock", 32'(lock_o), 32'd1);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    base_ccff  = ccff_seen;
    base_chken = chken_seen;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    check("abort_ccff_quiet", ccff_seen - base_ccff, 32'd0);
    check("abort_chken_quiet", chken_seen - base_chken, 32'd0);
    check("abort_clr_quiet", clr_seen - base_clr, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
